hdr_window_capture: RTL
=======================

// Module: hdr_window_capture
// PURPOSE
//  In-line AXI-Stream header capture stage for the packet parser. Passes every beat
//  from s_axis to m_axis and captures the first DEPTH beats of each packet into a flat
//  header window. Presents the window to the field extractor with a valid/ack handshake.
//  Stalls the next packet until the pending header is consumed. Handles short packets.
// PARAMETERS
//  DEPTH  4  header beats captured per packet (>=2); window width TDATA_WIDTH*DEPTH
// PORTS
//  clk            in   1                  clock, all logic on posedge
//  rst            in   1                  async active-low reset
//  s_axis_tdata   in   TDATA_WIDTH        input beat data
//  s_axis_tvalid  in   1                  input beat valid
//  s_axis_tready  out  1                  input beat ready
//  s_axis_tlast   in   1                  last beat of packet
//  m_axis_tdata   out  TDATA_WIDTH        output beat data (= s_axis_tdata)
//  m_axis_tvalid  out  1                  output beat valid
//  m_axis_tready  in   1                  downstream ready
//  m_axis_tlast   out  1                  output last (= s_axis_tlast)
//  hdr_data       out  TDATA_WIDTH*DEPTH  header window, beat k in [(k+1)*TDATA_WIDTH-1:k*TDATA_WIDTH]
//  hdr_beats      out  $clog2(DEPTH+1)    beats captured (1..DEPTH)
//  hdr_valid      out  1                  window valid, held until hdr_ack
//  hdr_ack        in   1                  consumer takes window
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE, beat_cnt=0, store zeroed, hdr_valid=0, hdr_beats=0.
//  - acc = s_axis_tvalid & s_axis_tready. Passthrough is combinational, no data latency.
//  - gate = (state!=IDLE) | !hdr_valid | hdr_ack.
//    s_axis_tready = m_axis_tready & gate; m_axis_tvalid = s_axis_tvalid & gate.
//  - FSM: IDLE -acc&!tlast-> CAPT; IDLE -acc&tlast-> IDLE (1-beat packet).
//    CAPT -acc&tlast-> IDLE; CAPT -acc & beat DEPTH-1 index & !tlast-> BODY.
//    BODY -acc&tlast-> IDLE; otherwise hold.
//  - Capture: on acc in IDLE/CAPT, store[beat_cnt]<=tdata, beat_cnt++. In IDLE, first
//    beat also clears slots 1..DEPTH-1 to zero (short packets leave zero tail).
//  - Completion = acc on beat index DEPTH-1, or acc with tlast in IDLE/CAPT. Next
//    cycle: hdr_data=store, hdr_beats=beats taken, hdr_valid=1. Latency 1 clk.
//  - hdr_data/hdr_beats update only at completion; stable while hdr_valid=1.
//  - hdr_valid clears on hdr_ack; hdr_ack with hdr_valid=0 ignored.
//  - Completion and hdr_ack in same cycle (first beat of a 1-beat packet): set wins.
//  - BODY beats are passed, never captured; beat_cnt saturates at DEPTH.
//  - Reset mid-packet: all state dropped, next accepted beat is a new packet start.
// CONFIGURATION
//  PP_HDR_KEEP_EN defined: adds ports s_axis_tkeep/m_axis_tkeep (TKEEP_WIDTH, in/out,
//   passed through) and hdr_keep (TKEEP_WIDTH*DEPTH, out); tkeep captured per beat like
//   tdata; unused slots zero; reset 0.
//  Not defined: no tkeep ports, no keep storage; all other behaviour identical.
// STRUCTURE
//  pp_package: TDATA_WIDTH, TKEEP_WIDTH=TDATA_WIDTH/8, typedef enum {IDLE,CAPT,BODY}
//   hdr_cap_state_t.
//  Sub-module hdr_beat_store: DEPTH-slot store with index write, clear-tail and flat
//   output; top holds FSM, handshake gating and hdr registers.
// TESTING (DEPTH=4, TDATA_WIDTH=64)
//  1 6-beat packet 0x11..0x66, m_tready=1 -> hdr_valid 1 clk after beat 4,
//    hdr_data={0x44,0x33,0x22,0x11}, hdr_beats=4; all 6 beats on m_axis, tlast on beat 6.
//  2 2-beat packet 0xA1,0xA2 -> hdr_beats=2, hdr_data={0,0,0xA2,0xA1}; 1-beat packet
//    0xB1 -> hdr_beats=1, slots 1..3 zero.
//  3 Back-to-back packets, hdr_ack withheld 10 clks -> s_axis_tready=0 on packet 2 first
//    beat until hdr_ack; packet 1 window unchanged; packet 2 captured correctly after.
//  4 m_axis_tready toggled every clk during capture -> no beat lost/duplicated, window
//    matches beats in order; hdr_ack in cycle of new first beat -> beat accepted.
//  5 Assert rst during beat 3 of packet -> outputs at reset values, next packet
//    0xC1..0xC4 captured as slots 0..3.
//  6 PP_HDR_KEEP_EN: tkeep 0xFF,0xFF,0x0F short packet -> hdr_keep={0,0x0F,0xFF,0xFF}.

Source files
------------

// File: rtl/hdr_window_capture_pkg.sv
// Shared types and widths for the packet-parser header capture slice.
package pp_package;

  localparam int TDATA_WIDTH = 64;
  localparam int TKEEP_WIDTH = TDATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAPT = 2'd1,
    BODY = 2'd2
  } hdr_cap_state_t;

endpackage

// File: rtl/hdr_beat_store.sv
// DEPTH-slot beat store with indexed write and clear-tail on packet start.
// Exposes the post-write contents combinationally so the owner can snapshot
// the completed window on the same edge as the final header beat is written.
module hdr_beat_store #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic                     clr_tail,
  input  logic [$clog2(DEPTH)-1:0] wr_idx,
  input  logic [W-1:0]             wr_data,
  output logic [W*DEPTH-1:0]       store_nxt
);

  logic [DEPTH-1:0][W-1:0] slot_q;
  logic [DEPTH-1:0][W-1:0] slot_d;

  // Next store contents: a packet's first beat zeroes slots 1..DEPTH-1 so short packets leave a zero tail
  always_comb begin
    slot_d = slot_q;
    if (wr_en) begin
      if (clr_tail) begin
        for (int k = 1; k < DEPTH; k++) begin
          slot_d[k] = '0;
        end
      end
      slot_d[wr_idx] = wr_data;
    end
  end

  // Store register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign store_nxt = slot_d;

endmodule

// File: rtl/hdr_window_capture.sv
// In-line AXI-Stream header capture: passes all beats through combinationally,
// captures the first DEPTH beats of each packet into a window presented with a
// valid/ack handshake, and holds off the next packet until the window is taken.
// Optional build macro PP_HDR_KEEP_EN adds tkeep passthrough and capture.
module hdr_window_capture
  import pp_package::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [TDATA_WIDTH-1:0]         s_axis_tdata,
  input  logic                           s_axis_tvalid,
  output logic                           s_axis_tready,
  input  logic                           s_axis_tlast,
  output logic [TDATA_WIDTH-1:0]         m_axis_tdata,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic                           m_axis_tlast,
`ifdef PP_HDR_KEEP_EN
  input  logic [TKEEP_WIDTH-1:0]         s_axis_tkeep,
  output logic [TKEEP_WIDTH-1:0]         m_axis_tkeep,
  output logic [TKEEP_WIDTH*DEPTH-1:0]   hdr_keep,
`endif
  output logic [TDATA_WIDTH*DEPTH-1:0]   hdr_data,
  output logic [$clog2(DEPTH+1)-1:0]     hdr_beats,
  output logic                           hdr_valid,
  input  logic                           hdr_ack
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);

  hdr_cap_state_t              state;
  logic [CNT_W-1:0]            beat_cnt;
  logic                        gate;
  logic                        acc;
  logic                        in_cap;
  logic                        last_slot;
  logic                        complete;
  logic [IDX_W-1:0]            wr_idx;
  logic [CNT_W-1:0]            beats_taken;
  logic [TDATA_WIDTH*DEPTH-1:0] data_nxt;

  // A new packet may only start once the pending window is gone or being taken now
  assign gate          = (state != IDLE) || !hdr_valid || hdr_ack;
  assign s_axis_tready = m_axis_tready && gate;
  assign m_axis_tvalid = s_axis_tvalid && gate;
  assign m_axis_tdata  = s_axis_tdata;
  assign m_axis_tlast  = s_axis_tlast;
  assign acc           = s_axis_tvalid && s_axis_tready;

  assign in_cap      = (state != BODY);
  assign last_slot   = (state == CAPT) && (beat_cnt == CNT_W'(DEPTH - 1));
  assign complete    = acc && in_cap && (s_axis_tlast || last_slot);
  assign wr_idx      = (state == IDLE) ? '0 : beat_cnt[IDX_W-1:0];
  assign beats_taken = (state == IDLE) ? CNT_W'(1) : beat_cnt + CNT_W'(1);

  hdr_beat_store #(
    .DEPTH (DEPTH),
    .W     (TDATA_WIDTH)
  ) u_data_store (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (acc && in_cap),
    .clr_tail  (state == IDLE),
    .wr_idx    (wr_idx),
    .wr_data   (s_axis_tdata),
    .store_nxt (data_nxt)
  );

`ifdef PP_HDR_KEEP_EN
  logic [TKEEP_WIDTH*DEPTH-1:0] keep_nxt;

  assign m_axis_tkeep = s_axis_tkeep;

  hdr_beat_store #(
    .DEPTH (DEPTH),
    .W     (TKEEP_WIDTH)
  ) u_keep_store (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (acc && in_cap),
    .clr_tail  (state == IDLE),
    .wr_idx    (wr_idx),
    .wr_data   (s_axis_tkeep),
    .store_nxt (keep_nxt)
  );

  // Keep window snapshot, updated together with the data window
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hdr_keep <= '0;
    end else if (complete) begin
      hdr_keep <= keep_nxt;
    end
  end
`endif

  // Packet framing FSM: beat_cnt indexes header slots and parks at DEPTH in BODY
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      beat_cnt <= '0;
    end else if (acc) begin
      case (state)
        IDLE: begin
          if (s_axis_tlast) begin
            beat_cnt <= '0;
          end else begin
            state    <= CAPT;
            beat_cnt <= CNT_W'(1);
          end
        end
        CAPT: begin
          if (s_axis_tlast) begin
            state    <= IDLE;
            beat_cnt <= '0;
          end else if (last_slot) begin
            state    <= BODY;
            beat_cnt <= CNT_W'(DEPTH);
          end else begin
            beat_cnt <= beat_cnt + CNT_W'(1);
          end
        end
        BODY: begin
          if (s_axis_tlast) begin
            state    <= IDLE;
            beat_cnt <= '0;
          end
        end
        default: begin
          state    <= IDLE;
          beat_cnt <= '0;
        end
      endcase
    end
  end

  // Window registers: snapshot on completion; a completion in the same cycle as an ack wins
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hdr_data  <= '0;
      hdr_beats <= '0;
      hdr_valid <= 1'b0;
    end else if (complete) begin
      hdr_data  <= data_nxt;
      hdr_beats <= beats_taken;
      hdr_valid <= 1'b1;
    end else if (hdr_ack) begin
      hdr_valid <= 1'b0;
    end
  end

endmodule
